// File: rtl/intc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : intc_pkg
// Purpose  : Shared constants, candidate record and hold-off state encoding
//            for the one-CPU interrupt selector.
// Revision : 1.0  initial release
// ============================================================================
package intc_pkg;

  localparam logic [7:0] INTC_VEC_ERR = 8'd9;
  localparam logic [7:0] INTC_VEC_NMI = 8'd11;
  localparam logic [4:0] INTC_LVL_NMI = 5'd16;
  localparam int         INTC_GRP_SZ  = 8;

  typedef struct packed {
    logic       vld;
    logic [3:0] lvl;
    logic [7:0] idx;
  } intc_cand_t;

  typedef enum logic [1:0] {
    HOLD_IDLE  = 2'd0,
    HOLD_ACKED = 2'd1,
    HOLD_FLUSH = 2'd2
  } intc_hold_e;

  // True when candidate a should replace b: higher level, or equal level with lower index
  function automatic logic intc_better(input intc_cand_t a, input intc_cand_t b);
    return a.vld && (!b.vld || (a.lvl > b.lvl) || ((a.lvl == b.lvl) && (a.idx < b.idx)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/intc_one_sel_grp.sv
`default_nettype none
// ============================================================================
// Module   : intc_one_sel_grp
// Purpose  : Combinational 8-way compare: highest level wins, lowest index
//            breaks ties. Invalid entries never win.
// Revision : 1.0  initial release
// ============================================================================
module intc_one_sel_grp
  import intc_pkg::*;
(
  input  intc_cand_t [INTC_GRP_SZ-1:0] cand_i,
  output intc_cand_t                   best_o
);

  // Linear scan keeping the best candidate seen so far
  always_comb begin
    best_o = '0;
    for (int i = 0; i < INTC_GRP_SZ; i++) begin
      if (intc_better(cand_i[i], best_o)) begin
        best_o = cand_i[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/intc_one_sel.sv
`default_nettype none
// ============================================================================
// Module   : intc_one_sel
// Purpose  : Interrupt selector for one CPU interface. Latches normal, NMI and
//            bus-error sources into pending state, picks the best enabled
//            candidate through a two-stage registered compare and presents it
//            as sl_req_o/sl_level_o/sl_vec_o, with an ack hold-off FSM.
// Config   : INTC_ONE_SEL_SYNC_EN - adds 2-flop synchronizers on int_src_i
//            and nmi_i (input edge -> request 5 clk instead of 3 clk).
// Revision : 1.0  initial release
// ============================================================================
module intc_one_sel
  import intc_pkg::*;
#(
  parameter int REG_NUM  = 1,
  parameter int VEC_BASE = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REG_NUM*32-1:0]   int_src_i,
  input  logic [REG_NUM*32-1:0]   int_edge_i,
  input  logic [REG_NUM*32-1:0]   int_en_i,
  input  logic [REG_NUM*128-1:0]  int_lvl_i,
  input  logic                    nmi_i,
  input  logic                    err_i,
  input  logic [3:0]              imask_i,
  input  logic [REG_NUM*32-1:0]   cp_intack_i,
  input  logic                    cp_intack_nmi_i,
  input  logic                    cp_intack_err_i,
  input  logic                    cp_intack_all_i,
  output logic                    sl_req_o,
  output logic [4:0]              sl_level_o,
  output logic [7:0]              sl_vec_o,
  output logic [REG_NUM*32-1:0]   pend_o
);

  localparam int N    = REG_NUM * 32;
  localparam int NGRP = N / INTC_GRP_SZ;
  localparam int NS2  = (NGRP + INTC_GRP_SZ - 1) / INTC_GRP_SZ;

  logic [N-1:0] src_sync;
  logic         nmi_sync;

`ifdef INTC_ONE_SEL_SYNC_EN
  logic [N-1:0] src_m_q, src_s_q;
  logic         nmi_m_q, nmi_s_q;

  // Two-flop synchronizers for the asynchronous source and NMI lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_m_q <= '0;
      src_s_q <= '0;
      nmi_m_q <= 1'b0;
      nmi_s_q <= 1'b0;
    end else begin
      src_m_q <= int_src_i;
      src_s_q <= src_m_q;
      nmi_m_q <= nmi_i;
      nmi_s_q <= nmi_m_q;
    end
  end

  assign src_sync = src_s_q;
  assign nmi_sync = nmi_s_q;
`else
  assign src_sync = int_src_i;
  assign nmi_sync = nmi_i;
`endif

  // ---------------------------------------------------------------- pending
  logic [N-1:0] src_prev_q, pend_q, pend_d;
  logic         nmi_prev_q, nmi_pend_q, nmi_pend_d;
  logic         err_pend_q, err_pend_d;

  // Next pending state: a new edge beats a same-cycle ack; level sources follow the line
  always_comb begin
    pend_d     = (int_edge_i & ((src_sync & ~src_prev_q) | (pend_q & ~cp_intack_i)))
               | (~int_edge_i & src_sync);
    nmi_pend_d = (nmi_sync & ~nmi_prev_q) | (nmi_pend_q & ~cp_intack_nmi_i);
    err_pend_d = err_i | (err_pend_q & ~cp_intack_err_i);
  end

  // Pending registers and edge-detect history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_prev_q <= '0;
      pend_q     <= '0;
      nmi_prev_q <= 1'b0;
      nmi_pend_q <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      src_prev_q <= src_sync;
      pend_q     <= pend_d;
      nmi_prev_q <= nmi_sync;
      nmi_pend_q <= nmi_pend_d;
      err_pend_q <= err_pend_d;
    end
  end

  assign pend_o = pend_q;

  // ---------------------------------------------------------------- stage 1
  intc_cand_t [N-1:0]    cand;
  intc_cand_t [NGRP-1:0] grp_d, grp_q;
  logic                  err_s1_q, nmi_s1_q;

  // Per-source candidate records; a level of zero never qualifies
  always_comb begin
    cand = '0;
    for (int i = 0; i < N; i++) begin
      cand[i].vld = pend_q[i] & int_en_i[i] & (int_lvl_i[4*i +: 4] != 4'd0);
      cand[i].lvl = int_lvl_i[4*i +: 4];
      cand[i].idx = 8'(i);
    end
  end

  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    intc_one_sel_grp u_grp (
      .cand_i (cand[g*INTC_GRP_SZ +: INTC_GRP_SZ]),
      .best_o (grp_d[g])
    );
  end

  // Stage-1 registers: group winners plus delayed ERR/NMI so all paths see equal latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grp_q    <= '0;
      err_s1_q <= 1'b0;
      nmi_s1_q <= 1'b0;
    end else begin
      grp_q    <= grp_d;
      err_s1_q <= err_pend_q;
      nmi_s1_q <= nmi_pend_q;
    end
  end

  // ---------------------------------------------------------------- stage 2
  intc_cand_t [NS2*INTC_GRP_SZ-1:0] s2_in;
  intc_cand_t [NS2-1:0]             s2_best;
  intc_cand_t                       best;

  // Pad the group winners out to whole 8-way compare blocks
  always_comb begin
    s2_in          = '0;
    s2_in[NGRP-1:0] = grp_q;
  end

  for (genvar g = 0; g < NS2; g++) begin : g_s2
    intc_one_sel_grp u_s2 (
      .cand_i (s2_in[g*INTC_GRP_SZ +: INTC_GRP_SZ]),
      .best_o (s2_best[g])
    );
  end

  if (NS2 == 1) begin : g_s2_single
    assign best = s2_best[0];
  end else begin : g_s2_tree
    intc_cand_t [INTC_GRP_SZ-1:0] fin_in;

    // Second-level compare over the per-block winners
    always_comb begin
      fin_in          = '0;
      fin_in[NS2-1:0] = s2_best;
    end

    intc_one_sel_grp u_fin (
      .cand_i (fin_in),
      .best_o (best)
    );
  end

  // ---------------------------------------------------------------- hold-off FSM
  intc_hold_e hold_q, hold_d;
  logic [1:0] cnt_q, cnt_d;

  // Suppress requests while an ack is in flight and for two cycles after it closes
  always_comb begin
    hold_d = hold_q;
    cnt_d  = cnt_q;
    case (hold_q)
      HOLD_IDLE: begin
        if (cp_intack_all_i) hold_d = HOLD_ACKED;
      end
      HOLD_ACKED: begin
        if (!cp_intack_all_i) begin
          hold_d = HOLD_FLUSH;
          cnt_d  = 2'd2;
        end
      end
      HOLD_FLUSH: begin
        if (cp_intack_all_i) begin
          hold_d = HOLD_ACKED;
        end else begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_d == 2'd0) hold_d = HOLD_IDLE;
        end
      end
      default: hold_d = HOLD_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- output
  logic       req_raw, sl_req_d;
  logic [4:0] sl_level_d;
  logic [7:0] sl_vec_d;
  logic       sl_req_q;
  logic [4:0] sl_level_q;
  logic [7:0] sl_vec_q;

  // Final priority ERR > NMI > masked normal; level/vec hold when nothing qualifies
  always_comb begin
    req_raw    = 1'b1;
    sl_level_d = sl_level_q;
    sl_vec_d   = sl_vec_q;
    if (err_s1_q) begin
      sl_level_d = INTC_LVL_NMI;
      sl_vec_d   = INTC_VEC_ERR;
    end else if (nmi_s1_q) begin
      sl_level_d = INTC_LVL_NMI;
      sl_vec_d   = INTC_VEC_NMI;
    end else if (best.vld && (best.lvl > imask_i)) begin
      sl_level_d = {1'b0, best.lvl};
      sl_vec_d   = 8'(VEC_BASE) + best.idx;
    end else begin
      req_raw    = 1'b0;
    end
    sl_req_d = req_raw && (hold_d == HOLD_IDLE);
  end

  // Output registers and hold-off state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sl_req_q   <= 1'b0;
      sl_level_q <= '0;
      sl_vec_q   <= '0;
      hold_q     <= HOLD_IDLE;
      cnt_q      <= '0;
    end else begin
      sl_req_q   <= sl_req_d;
      sl_level_q <= sl_level_d;
      sl_vec_q   <= sl_vec_d;
      hold_q     <= hold_d;
      cnt_q      <= cnt_d;
    end
  end

  assign sl_req_o   = sl_req_q;
  assign sl_level_o = sl_level_q;
  assign sl_vec_o   = sl_vec_q;

endmodule
`default_nettype wire

// File: tb/tb_intc_one_sel.sv
`default_nettype none
// ============================================================================
// Module   : tb_intc_one_sel
// Purpose  : Self-checking bench for intc_one_sel (REG_NUM=1, VEC_BASE=64):
//            vector table, directed corner sequences and random stimulus,
//            all cross-checked every cycle against a history-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_intc_one_sel;

  localparam int NSRC     = 32;
  localparam int VEC_BASE = 64;
`ifdef INTC_ONE_SEL_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif
  localparam int LAT = D + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   src, edg, en, ack;
  logic [127:0]  lvl;
  logic          nmi, err, ack_nmi, ack_err, ack_all;
  logic [3:0]    imask;
  logic          sl_req;
  logic [4:0]    sl_level;
  logic [7:0]    sl_vec;
  logic [31:0]   pend;

  int n_chk = 0;
  int n_err = 0;

  intc_one_sel #(.REG_NUM(1), .VEC_BASE(VEC_BASE)) dut (
    .clk             (clk),
    .rst             (rst),
    .int_src_i       (src),
    .int_edge_i      (edg),
    .int_en_i        (en),
    .int_lvl_i       (lvl),
    .nmi_i           (nmi),
    .err_i           (err),
    .imask_i         (imask),
    .cp_intack_i     (ack),
    .cp_intack_nmi_i (ack_nmi),
    .cp_intack_err_i (ack_err),
    .cp_intack_all_i (ack_all),
    .sl_req_o        (sl_req),
    .sl_level_o      (sl_level),
    .sl_vec_o        (sl_vec),
    .pend_o          (pend)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  logic [31:0]  in_h [0:3];
  logic         nmi_h [0:3];
  logic [31:0]  pm1, pm2, en1;
  logic [127:0] lvl1;
  logic         nm1, nm2, em1, em2;
  logic [2:0]   aa;
  logic         m_req;
  logic [4:0]   m_lvl;
  logic [7:0]   m_vec;

  task automatic model_reset();
    for (int j = 0; j < 4; j++) begin
      in_h[j]  = '0;
      nmi_h[j] = 1'b0;
    end
    pm1 = '0; pm2 = '0; en1 = '0; lvl1 = '0;
    nm1 = 0; nm2 = 0; em1 = 0; em2 = 0;
    aa = '0; m_req = 0; m_lvl = '0; m_vec = '0;
  endtask

  // One clock edge of the reference: output from state two edges back, then new pending
  task automatic model_step();
    logic [31:0] sn, sp, np;
    logic        raw, nn, ne;
    logic [3:0]  bl;
    int          bi;
    raw = 1'b0; bl = 4'd0; bi = 0;
    if (em2) begin
      raw = 1'b1; m_lvl = 5'd16; m_vec = 8'd9;
    end else if (nm2) begin
      raw = 1'b1; m_lvl = 5'd16; m_vec = 8'd11;
    end else begin
      for (int i = 0; i < NSRC; i++)
        if (pm2[i] && en1[i] && (lvl1[4*i +: 4] > bl)) begin
          bl = lvl1[4*i +: 4];
          bi = i;
        end
      if (bl > imask) begin
        raw = 1'b1; m_lvl = {1'b0, bl}; m_vec = 8'(VEC_BASE + bi);
      end
    end
    aa    = {aa[1:0], ack_all};
    m_req = raw && (aa == 3'b000);

    for (int j = 3; j > 0; j--) begin
      in_h[j]  = in_h[j-1];
      nmi_h[j] = nmi_h[j-1];
    end
    in_h[0]  = src;
    nmi_h[0] = nmi;
    sn = in_h[D];
    sp = in_h[D+1];
    for (int i = 0; i < NSRC; i++) begin
      if (!edg[i])                np[i] = sn[i];
      else if (sn[i] && !sp[i])   np[i] = 1'b1;
      else if (ack[i])            np[i] = 1'b0;
      else                        np[i] = pm1[i];
    end
    if (nmi_h[D] && !nmi_h[D+1]) nn = 1'b1;
    else if (ack_nmi)            nn = 1'b0;
    else                         nn = nm1;
    if (err)          ne = 1'b1;
    else if (ack_err) ne = 1'b0;
    else              ne = em1;
    pm2 = pm1; pm1 = np;
    nm2 = nm1; nm1 = nn;
    em2 = em1; em1 = ne;
    en1 = en;  lvl1 = lvl;
  endtask

  // ---------------------------------------------------------------- checks
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("model_req",  32'(sl_req),   32'(m_req));
    chk("model_lvl",  32'(sl_level), 32'(m_lvl));
    chk("model_vec",  32'(sl_vec),   32'(m_vec));
    chk("model_pend", pend,          pm1);
  endtask

  task automatic chk_sl(input string nm, input logic r, input logic [4:0] l, input logic [7:0] v);
    chk({nm, "_req"}, 32'(sl_req), 32'(r));
    if (r) begin
      chk({nm, "_lvl"}, 32'(sl_level), 32'(l));
      chk({nm, "_vec"}, 32'(sl_vec),   32'(v));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_step();
    #1;
    chk_model();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic set_lvl(input int i, input logic [3:0] v);
    lvl[4*i +: 4] = v;
  endtask

  // ---------------------------------------------------------------- vector table
  typedef struct {
    int         ia;
    logic [3:0] la;
    int         ib;
    logic [3:0] lb;
    logic       en_b;
    logic [3:0] msk;
    logic       e_req;
    logic [4:0] e_lvl;
    logic [7:0] e_vec;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{0,  4'd3,  31, 4'd3,  1'b1, 4'd0,  1'b1, 5'd3,  8'd64};
    tbl[1] = '{8,  4'd2,  15, 4'd9,  1'b1, 4'd0,  1'b1, 5'd9,  8'd79};
    tbl[2] = '{7,  4'd5,  24, 4'd14, 1'b0, 4'd0,  1'b1, 5'd5,  8'd71};
    tbl[3] = '{12, 4'd0,  13, 4'd0,  1'b1, 4'd0,  1'b0, 5'd0,  8'd0};
    tbl[4] = '{16, 4'd15, 23, 4'd15, 1'b1, 4'd14, 1'b1, 5'd15, 8'd80};
    tbl[5] = '{30, 4'd8,  1,  4'd7,  1'b1, 4'd8,  1'b0, 5'd0,  8'd0};
    tbl[6] = '{4,  4'd1,  28, 4'd2,  1'b1, 4'd1,  1'b1, 5'd2,  8'd92};
    tbl[7] = '{9,  4'd6,  25, 4'd6,  1'b1, 4'd0,  1'b1, 5'd6,  8'd73};

    rst = 1'b1;
    src = '0; edg = '0; en = '0; ack = '0; lvl = '0;
    nmi = 0; err = 0; ack_nmi = 0; ack_err = 0; ack_all = 0; imask = '0;
    model_reset();
    #2;
    chk("reset_req",  32'(sl_req),   32'd0);
    chk("reset_lvl",  32'(sl_level), 32'd0);
    chk("reset_vec",  32'(sl_vec),   32'd0);
    chk("reset_pend", pend,          32'd0);
    run(2);
    rst = 1'b0;
    run(2);

    // Level-source vector table
    foreach (tbl[k]) begin
      edg = '0; lvl = '0;
      en  = '1;
      en[tbl[k].ib] = tbl[k].en_b;
      set_lvl(tbl[k].ia, tbl[k].la);
      set_lvl(tbl[k].ib, tbl[k].lb);
      imask = tbl[k].msk;
      src = '0;
      src[tbl[k].ia] = 1'b1;
      src[tbl[k].ib] = 1'b1;
      run(LAT + 2);
      chk_sl($sformatf("tbl%0d", k), tbl[k].e_req, tbl[k].e_lvl, tbl[k].e_vec);
      src = '0; imask = '0;
      run(LAT + 2);
    end

    // 1: edge source latency and ack
    edg = '1; en = '1; lvl = '0; set_lvl(5, 4'd7);
    src[5] = 1'b1;
    step(); src[5] = 1'b0;
    run(LAT - 2);
    chk("t1_early_req", 32'(sl_req), 32'd0);
    step();
    chk_sl("t1", 1'b1, 5'd7, 8'd69);
    ack[5] = 1'b1; step(); ack = '0;
    chk("t1_pend_clr", 32'(pend[5]), 32'd0);
    run(3);
    chk("t1_req_drop", 32'(sl_req), 32'd0);

    // 2: tie resolved to lower index, then a level change
    set_lvl(3, 4'd9); set_lvl(20, 4'd9);
    src[3] = 1'b1; src[20] = 1'b1;
    step(); src = '0;
    run(LAT);
    chk_sl("t2_tie", 1'b1, 5'd9, 8'd67);
    set_lvl(20, 4'd12);
    step();
    chk_sl("t2_lvl_1clk", 1'b1, 5'd9, 8'd67);
    step();
    chk_sl("t2_lvl_2clk", 1'b1, 5'd12, 8'd84);
    ack[3] = 1'b1; ack[20] = 1'b1; step(); ack = '0;
    run(3);

    // 3: mask boundary
    set_lvl(2, 4'd4); imask = 4'd4;
    src[2] = 1'b1; step(); src = '0;
    run(LAT);
    chk("t3_masked", 32'(sl_req), 32'd0);
    imask = 4'd3;
    step();
    chk_sl("t3_unmasked", 1'b1, 5'd4, 8'd66);
    ack[2] = 1'b1; imask = '0; step(); ack = '0;
    run(3);

    // 4: ERR over NMI over normal
    set_lvl(1, 4'd15);
    src[1] = 1'b1; step(); src = '0;
    run(LAT);
    chk_sl("t4_norm", 1'b1, 5'd15, 8'd65);
    err = 1'b1; nmi = 1'b1; step(); err = 1'b0;
    run(LAT);
    chk_sl("t4_err", 1'b1, 5'd16, 8'd9);
    ack_err = 1'b1; step(); ack_err = 1'b0;
    run(2);
    chk_sl("t4_nmi", 1'b1, 5'd16, 8'd11);
    ack_nmi = 1'b1; step(); ack_nmi = 1'b0;
    run(2);
    chk_sl("t4_back", 1'b1, 5'd15, 8'd65);
    nmi = 1'b0; ack[1] = 1'b1; step(); ack = '0;
    run(3);

    // 5: ack window with same-cycle re-edge, then hold-off release
    set_lvl(7, 4'd5);
    src[7] = 1'b1; step(); src = '0;
    run(LAT);
    chk_sl("t5_pre", 1'b1, 5'd5, 8'd71);
    src[7] = 1'b1;
    for (int c = 0; c <= D; c++) begin
      if (c == D) begin ack[7] = 1'b1; ack_all = 1'b1; end
      step();
      if (c == 0) src[7] = 1'b0;
    end
    ack = '0;
    chk("t5_pend_kept", 32'(pend[7]), 32'd1);
    chk("t5_acked0", 32'(sl_req), 32'd0);
    for (int c = 1; c < 3; c++) begin
      step();
      chk($sformatf("t5_acked%0d", c), 32'(sl_req), 32'd0);
    end
    ack_all = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      chk($sformatf("t5_flush%0d", c), 32'(sl_req), 32'd0);
    end
    step();
    chk_sl("t5_resume", 1'b1, 5'd5, 8'd71);
    ack[7] = 1'b1; step(); ack = '0;
    run(3);

    // 6: async reset during a level request
    edg[10] = 1'b0; set_lvl(10, 4'd6); src[10] = 1'b1;
    run(LAT + 1);
    chk_sl("t6_pre", 1'b1, 5'd6, 8'd74);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_rst_req",  32'(sl_req),   32'd0);
    chk("t6_rst_lvl",  32'(sl_level), 32'd0);
    chk("t6_rst_vec",  32'(sl_vec),   32'd0);
    chk("t6_rst_pend", pend,          32'd0);
    run(2);
    rst = 1'b0;
    run(LAT - 1);
    chk("t6_early_req", 32'(sl_req), 32'd0);
    step();
    chk_sl("t6_back", 1'b1, 5'd6, 8'd74);
    src = '0;
    run(LAT + 1);

    // Random stimulus against the model
    edg = $urandom;
    for (int c = 0; c < 600; c++) begin
      src     = $urandom & $urandom;
      en      = $urandom | $urandom;
      if (c % 16 == 0) lvl = {$urandom, $urandom, $urandom, $urandom};
      if (c % 8 == 0)  imask = 4'($urandom_range(0, 15));
      ack     = $urandom & $urandom & $urandom;
      ack_nmi = ($urandom_range(0, 3) == 0);
      ack_err = ($urandom_range(0, 3) == 0);
      err     = ($urandom_range(0, 7) == 0);
      nmi     = ($urandom_range(0, 3) == 0);
      ack_all = ($urandom_range(0, 9) == 0);
      if (c == 300) edg = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
